// File: rtl/uart_cmd_parser_if.sv
// Byte-stream handshake into the command parser: one byte per rx_valid cycle.
interface uart_cmd_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (output rx_data, output rx_valid);
  modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/uart_cmd_parser.sv
// ASCII command parser for a clock/alarm: "T hhmmss CR", "A hhmm CR", "? CR".
// Digits are collected as packed BCD, range-checked on CR, then loaded with a one-cycle pulse.
module uart_cmd_parser #(
  parameter int CLOCK_FREQ     = 50000000,
  parameter int TIMEOUT_MS     = 100,
  parameter int TIMEOUT_CYCLES = CLOCK_FREQ / 1000 * TIMEOUT_MS
) (
  input  logic             clk,
  input  logic             reset_n,
  uart_cmd_parser_if.slave rx,
  output logic [7:0]       time_hh,
  output logic [7:0]       time_mm,
  output logic [7:0]       time_ss,
  output logic [7:0]       alarm_hh,
  output logic [7:0]       alarm_mm,
  output logic             set_time,
  output logic             set_alarm,
  output logic             query,
  output logic             cmd_err,
  output logic             busy
);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CH_T  = 8'h54;
  localparam logic [7:0] CH_A  = 8'h41;
  localparam logic [7:0] CH_Q  = 8'h3F;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  typedef enum logic [1:0] {S_IDLE, S_DIGITS, S_EOL, S_FLUSH} state_t;
  typedef enum logic [1:0] {OP_TIME, OP_ALARM, OP_QUERY} op_t;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [2:0]       left_q, left_d;
  logic [23:0]      dig_q, dig_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       time_hh_q, time_hh_d, time_mm_q, time_mm_d, time_ss_q, time_ss_d;
  logic [7:0]       alarm_hh_q, alarm_hh_d, alarm_mm_q, alarm_mm_d;
  logic             set_time_q, set_time_d, set_alarm_q, set_alarm_d;
  logic             query_q, query_d, cmd_err_q, cmd_err_d;
  logic             is_digit, in_cmd;

  function automatic logic hh_ok(input logic [7:0] v);
    return (v[7:4] < 4'd2) || ((v[7:4] == 4'd2) && (v[3:0] <= 4'd3));
  endfunction

  function automatic logic ms_ok(input logic [7:0] v);
    return v[7:4] <= 4'd5;
  endfunction

  assign is_digit = (rx.rx_data >= 8'h30) && (rx.rx_data <= 8'h39);
  assign in_cmd   = (state_q == S_DIGITS) || (state_q == S_EOL);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    left_d      = left_q;
    dig_d       = dig_q;
    tmo_d       = '0;
    time_hh_d   = time_hh_q;
    time_mm_d   = time_mm_q;
    time_ss_d   = time_ss_q;
    alarm_hh_d  = alarm_hh_q;
    alarm_mm_d  = alarm_mm_q;
    set_time_d  = 1'b0;
    set_alarm_d = 1'b0;
    query_d     = 1'b0;
    cmd_err_d   = 1'b0;

    // A byte on the terminal-count cycle always wins over the timeout.
    if (in_cmd && !rx.rx_valid) begin
      if (tmo_q == TMO_LAST) begin
        cmd_err_d = 1'b1;
        state_d   = S_IDLE;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    if (rx.rx_valid) begin
      case (state_q)
        S_IDLE: begin
          case (rx.rx_data)
            CH_T: begin
              state_d = S_DIGITS;
              op_d    = OP_TIME;
              left_d  = 3'd6;
              dig_d   = '0;
            end
            CH_A: begin
              state_d = S_DIGITS;
              op_d    = OP_ALARM;
              left_d  = 3'd4;
              dig_d   = '0;
            end
            CH_Q: begin
              state_d = S_EOL;
              op_d    = OP_QUERY;
            end
            CH_CR, CH_LF: ;
            default: begin
              cmd_err_d = 1'b1;
              state_d   = S_FLUSH;
            end
          endcase
        end
        S_DIGITS: begin
          if (is_digit) begin
            dig_d  = {dig_q[19:0], rx.rx_data[3:0]};
            left_d = left_q - 3'd1;
            if (left_q == 3'd1) state_d = S_EOL;
          end else begin
            cmd_err_d = 1'b1;
            state_d   = S_FLUSH;
          end
        end
        S_EOL: begin
          if (rx.rx_data == CH_CR) begin
            state_d = S_IDLE;
            case (op_q)
              OP_TIME: begin
                if (hh_ok(dig_q[23:16]) && ms_ok(dig_q[15:8]) && ms_ok(dig_q[7:0])) begin
                  time_hh_d  = dig_q[23:16];
                  time_mm_d  = dig_q[15:8];
                  time_ss_d  = dig_q[7:0];
                  set_time_d = 1'b1;
                end else begin
                  cmd_err_d = 1'b1;
                end
              end
              OP_ALARM: begin
                if (hh_ok(dig_q[15:8]) && ms_ok(dig_q[7:0])) begin
                  alarm_hh_d  = dig_q[15:8];
                  alarm_mm_d  = dig_q[7:0];
                  set_alarm_d = 1'b1;
                end else begin
                  cmd_err_d = 1'b1;
                end
              end
              default: query_d = 1'b1;
            endcase
          end else begin
            cmd_err_d = 1'b1;
            state_d   = S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (rx.rx_data == CH_CR) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_TIME;
      left_q      <= '0;
      dig_q       <= '0;
      tmo_q       <= '0;
      time_hh_q   <= '0;
      time_mm_q   <= '0;
      time_ss_q   <= '0;
      alarm_hh_q  <= '0;
      alarm_mm_q  <= '0;
      set_time_q  <= 1'b0;
      set_alarm_q <= 1'b0;
      query_q     <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      left_q      <= left_d;
      dig_q       <= dig_d;
      tmo_q       <= tmo_d;
      time_hh_q   <= time_hh_d;
      time_mm_q   <= time_mm_d;
      time_ss_q   <= time_ss_d;
      alarm_hh_q  <= alarm_hh_d;
      alarm_mm_q  <= alarm_mm_d;
      set_time_q  <= set_time_d;
      set_alarm_q <= set_alarm_d;
      query_q     <= query_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign time_hh   = time_hh_q;
  assign time_mm   = time_mm_q;
  assign time_ss   = time_ss_q;
  assign alarm_hh  = alarm_hh_q;
  assign alarm_mm  = alarm_mm_q;
  assign set_time  = set_time_q;
  assign set_alarm = set_alarm_q;
  assign query     = query_q;
  assign cmd_err   = cmd_err_q;
  assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: a string-level command model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_uart_cmd_parser;
  localparam int TO = 20;

  logic       clk;
  logic       reset_n;
  logic [7:0] time_hh, time_mm, time_ss, alarm_hh, alarm_mm;
  logic       set_time, set_alarm, query, cmd_err, busy;

  uart_cmd_parser_if rx();

  uart_cmd_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .time_hh   (time_hh),
    .time_mm   (time_mm),
    .time_ss   (time_ss),
    .alarm_hh  (alarm_hh),
    .alarm_mm  (alarm_mm),
    .set_time  (set_time),
    .set_alarm (set_alarm),
    .query     (query),
    .cmd_err   (cmd_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model: commands as byte strings ----------------
  logic [7:0] line[$];
  bit         flushing = 0;
  int         gap = 0;
  logic [7:0] e_hh = 0, e_mm = 0, e_ss = 0, e_ahh = 0, e_amm = 0;
  bit         e_st = 0, e_sa = 0, e_q = 0, e_err = 0, e_busy = 0;

  function automatic int need_len(input logic [7:0] op);
    if (op == 8'h54) return 7;
    if (op == 8'h41) return 5;
    return 1;
  endfunction

  function automatic int dval(input logic [7:0] c);
    return int'(c) - 48;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  always @(posedge clk) begin
    logic [7:0] b;
    int hh, mm, ss;
    e_st = 0; e_sa = 0; e_q = 0; e_err = 0;
    if (!reset_n) begin
      line.delete(); flushing = 0; gap = 0;
      e_hh = 0; e_mm = 0; e_ss = 0; e_ahh = 0; e_amm = 0;
    end else if (rx.rx_valid) begin
      b = rx.rx_data;
      gap = 0;
      if (flushing) begin
        if (b == 8'h0D) flushing = 0;
      end else if (line.size() == 0) begin
        if (b == 8'h54 || b == 8'h41 || b == 8'h3F) line.push_back(b);
        else if (b != 8'h0D && b != 8'h0A) begin e_err = 1; flushing = 1; end
      end else if (line.size() < need_len(line[0])) begin
        if (b >= 8'h30 && b <= 8'h39) line.push_back(b);
        else begin e_err = 1; flushing = 1; line.delete(); end
      end else begin
        if (b != 8'h0D) begin
          e_err = 1; flushing = 1;
        end else if (line[0] == 8'h3F) begin
          e_q = 1;
        end else begin
          hh = dval(line[1]) * 10 + dval(line[2]);
          mm = dval(line[3]) * 10 + dval(line[4]);
          if (line[0] == 8'h54) begin
            ss = dval(line[5]) * 10 + dval(line[6]);
            if (hh <= 23 && mm <= 59 && ss <= 59) begin
              e_hh = to_bcd(hh); e_mm = to_bcd(mm); e_ss = to_bcd(ss); e_st = 1;
            end else e_err = 1;
          end else begin
            if (hh <= 23 && mm <= 59) begin
              e_ahh = to_bcd(hh); e_amm = to_bcd(mm); e_sa = 1;
            end else e_err = 1;
          end
        end
        line.delete();
      end
    end else if (line.size() != 0) begin
      gap++;
      if (gap == TO) begin e_err = 1; line.delete(); gap = 0; end
    end
    e_busy = (line.size() != 0) || flushing;
  end

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      chk("set_time",  set_time,  e_st);
      chk("set_alarm", set_alarm, e_sa);
      chk("query",     query,     e_q);
      chk("cmd_err",   cmd_err,   e_err);
      chk("busy",      busy,      e_busy);
      chk("time_hh",   time_hh,   e_hh);
      chk("time_mm",   time_mm,   e_mm);
      chk("time_ss",   time_ss,   e_ss);
      chk("alarm_hh",  alarm_hh,  e_ahh);
      chk("alarm_mm",  alarm_mm,  e_amm);
      chk("one_pulse", 32'($countones({set_time, set_alarm, query, cmd_err}) <= 1), 1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      rx.rx_data  = s[i];
      rx.rx_valid = 1'b1;
      step();
    end
    rx.rx_valid = 1'b0;
    rx.rx_data  = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int errs;
    reset_n     = 1'b0;
    rx.rx_valid = 1'b0;
    rx.rx_data  = 8'h00;
    repeat (3) step();
    chk("rst_busy",     busy,     0);
    chk("rst_time_hh",  time_hh,  0);
    chk("rst_alarm_mm", alarm_mm, 0);
    chk("rst_cmd_err",  cmd_err,  0);
    reset_n = 1'b1;
    step();

    send("T123456\015");
    chk("t1_set_time", set_time, 1);
    chk("t1_hh", time_hh, 8'h12);
    chk("t1_mm", time_mm, 8'h34);
    chk("t1_ss", time_ss, 8'h56);
    step();
    chk("t1_busy_after", busy, 0);
    chk("t1_pulse_len",  set_time, 0);

    send("A2460\015");
    chk("a_range_err",   cmd_err,   1);
    chk("a_range_noset", set_alarm, 0);
    chk("a_range_hh",    alarm_hh,  8'h00);
    chk("a_range_mm",    alarm_mm,  8'h00);
    step();

    send("T12X");
    chk("bad_digit_err", cmd_err, 1);
    send("\015");
    chk("flush_cr_noerr", cmd_err, 0);
    chk("flush_cr_idle",  busy,    0);
    send("?\015");
    chk("query_pulse", query, 1);
    step();

    send("T010203\015A1234\015");
    chk("b2b_set_alarm", set_alarm, 1);
    chk("b2b_ahh", alarm_hh, 8'h12);
    chk("b2b_amm", alarm_mm, 8'h34);
    chk("b2b_ss",  time_ss,  8'h03);

    send("t");
    chk("lower_t_err", cmd_err, 1);
    send("\015\012?\015");
    chk("lf_ignored_query", query, 1);
    send("T240000\015T235960\015A0000\015");
    chk("a0000_set", set_alarm, 1);
    chk("a0000_hh",  alarm_hh, 8'h00);
    send("?X\015");
    step();

    send("T12");
    errs = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (cmd_err) errs++;
    end
    chk("timeout_err_count", errs, 1);
    chk("timeout_busy", busy, 0);
    send("A0705\015");
    chk("after_to_set_alarm", set_alarm, 1);
    chk("after_to_ahh", alarm_hh, 8'h07);
    chk("after_to_amm", alarm_mm, 8'h05);

    send("T1");
    errs = 0;
    for (int i = 0; i < TO - 1; i++) begin
      step();
      if (cmd_err) errs++;
    end
    send("53456\015");
    if (cmd_err) errs++;
    chk("tc_byte_wins_noerr", errs, 0);
    chk("tc_set_time", set_time, 1);
    chk("tc_hh", time_hh, 8'h15);
    chk("tc_ss", time_ss, 8'h56);
    step();

    send("T0959");
    reset_n = 1'b0;
    #1;
    chk("midrst_busy",    busy,     0);
    chk("midrst_time_hh", time_hh,  8'h00);
    chk("midrst_time_ss", time_ss,  8'h00);
    chk("midrst_alarm",   alarm_hh, 8'h00);
    repeat (2) step();
    reset_n = 1'b1;
    step();
    send("T235959\015");
    chk("post_rst_set", set_time, 1);
    chk("post_rst_hh",  time_hh, 8'h23);
    chk("post_rst_mm",  time_mm, 8'h59);
    chk("post_rst_ss",  time_ss, 8'h59);

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
